// File: rtl/freelist_pkg.sv
// Shared rename package: freelist size defaults, depth derivation and the
// 4-slot bus packing helper (slot j occupies bits [(j+1)*w-1 : j*w]).
package freelist_pkg;

  localparam int unsigned WIDTH_DEF = 6;
  localparam int unsigned NARCH_DEF = 32;
  localparam int unsigned SLOTS     = 4;

  // Number of registers that live in the free list (must be a power of two).
  function automatic int unsigned depth_of(input int unsigned w, input int unsigned narch);
    return (32'd1 << w) - narch;
  endfunction

  // Low bit index of slot j on a 4-slot packed address bus.
  function automatic int unsigned slot_lo(input int unsigned j, input int unsigned w);
    return j * w;
  endfunction

endpackage

// File: rtl/freelist_if.sv
// Rename-side bundle of the freelist: allocation request/response, commit
// frees and the free-entry count.
//   i_req      per-slot allocation request
//   o_addr4x   allocated registers, 4 packed slots
//   o_stall    request cannot be satisfied this cycle
//   i_freeEn   per-slot free enable from commit
//   i_free4x   registers being released, 4 packed slots
//   o_count    registered number of free entries
//   o_err      (FREELIST_ERR_EN only) sticky free-misuse flag
interface freelist_if
  import freelist_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NARCH = NARCH_DEF
);
  localparam int unsigned DEPTH = depth_of(WIDTH, NARCH);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic [SLOTS-1:0]       i_req;
  logic [SLOTS*WIDTH-1:0] o_addr4x;
  logic                   o_stall;
  logic [SLOTS-1:0]       i_freeEn;
  logic [SLOTS*WIDTH-1:0] i_free4x;
  logic [CW-1:0]          o_count;
`ifdef FREELIST_ERR_EN
  logic                   o_err;
`endif

  modport master (
    output i_req, i_freeEn, i_free4x,
    input  o_addr4x, o_stall, o_count
`ifdef FREELIST_ERR_EN
    , input o_err
`endif
  );

  modport slave (
    input  i_req, i_freeEn, i_free4x,
    output o_addr4x, o_stall, o_count
`ifdef FREELIST_ERR_EN
    , output o_err
`endif
  );

endinterface

// File: rtl/freelist_prefix.sv
// 4-bit mask -> exclusive prefix counts per slot plus total popcount.
//   mask   in   per-slot valid bits
//   pre    out  pre[j] = number of set bits below slot j
//   total  out  popcount(mask)
module freelist_prefix (
  input  logic [3:0]      mask,
  output logic [3:0][2:0] pre,
  output logic [2:0]      total
);

  logic [2:0] acc;

  // Running sum; each slot sees the count before adding its own bit.
  always_comb begin
    pre = '0;
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      pre[j] = acc;
      acc    = acc + 3'(mask[j]);
    end
    total = acc;
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list for the 4-wide rename stage. Circular buffer
// of free register numbers: allocation reads at head (all-or-nothing, up to
// four per cycle), commit frees write at tail (up to four per cycle).
// Optional checking is enabled with the FREELIST_ERR_EN macro, which adds
// the sticky o_err flag to the interface.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   fl       freelist_if.slave (request/addresses/stall/frees/count)
module freelist
  import freelist_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NARCH = NARCH_DEF
) (
  input logic       i_clk,
  input logic       i_rst_n,
  freelist_if.slave fl
);

  localparam int unsigned DEPTH = depth_of(WIDTH, NARCH);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [3:0][2:0]  req_pre, free_pre;
  logic [2:0]       n_req, n_free, n_alloc;
  logic [3:0]       free_vld;
  logic             stall;
  logic [SLOTS*WIDTH-1:0] addr4x;

  // Freed p0 is dropped so it never enters the list.
  always_comb begin
    free_vld = '0;
    for (int j = 0; j < 4; j++) begin
      free_vld[j] = fl.i_freeEn[j] && (fl.i_free4x[slot_lo(j, WIDTH) +: WIDTH] != '0);
    end
  end

  freelist_prefix u_req_prefix (
    .mask  (fl.i_req),
    .pre   (req_pre),
    .total (n_req)
  );

  freelist_prefix u_free_prefix (
    .mask  (free_vld),
    .pre   (free_pre),
    .total (n_free)
  );

  // Allocation response and next-state pointers/count.
  always_comb begin
    stall   = 32'(n_req) > 32'(count_q);
    n_alloc = stall ? 3'd0 : n_req;
    addr4x  = '0;
    for (int j = 0; j < 4; j++) begin
      if (fl.i_req[j] && !stall) begin
        addr4x[slot_lo(j, WIDTH) +: WIDTH] = mem[head_q + PW'(req_pre[j])];
      end
    end
    head_d  = head_q + PW'(n_alloc);
    tail_d  = tail_q + PW'(n_free);
    count_d = count_q - CW'(n_alloc) + CW'(n_free);
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // List storage; reset contents are the unmapped registers NARCH..2^WIDTH-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= WIDTH'(NARCH + 32'(i));
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (free_vld[j]) begin
          mem[tail_q + PW'(free_pre[j])] <= fl.i_free4x[slot_lo(j, WIDTH) +: WIDTH];
        end
      end
    end
  end

  assign fl.o_addr4x = addr4x;
  assign fl.o_stall  = stall;
  assign fl.o_count  = count_q;

`ifdef FREELIST_ERR_EN
  logic [CW-1:0] seen_q, seen_d;
  logic          err_q, err_d;
  logic          overflow, early_free;
  logic [31:0]   seen_sum;

  // Overflow of capacity, or a free of a never-allocated architectural
  // register while fewer than DEPTH allocations have happened since reset.
  always_comb begin
    overflow   = (32'(count_q) + 32'(n_free) - 32'(n_alloc)) > DEPTH;
    early_free = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (free_vld[j] && (32'(fl.i_free4x[slot_lo(j, WIDTH) +: WIDTH]) < NARCH)
          && (32'(seen_q) < DEPTH)) begin
        early_free = 1'b1;
      end
    end
    seen_sum = 32'(seen_q) + 32'(n_alloc);
    seen_d   = (seen_sum > DEPTH) ? CW'(DEPTH) : CW'(seen_sum);
    err_d    = err_q || overflow || early_free;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seen_q <= '0;
      err_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      err_q  <= err_d;
    end
  end

  assign fl.o_err = err_q;
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed scenarios followed by random
// alloc/free traffic, compared against a queue-based model of the free list.
module tb_freelist;
  import freelist_pkg::*;

  localparam int W  = 6;
  localparam int NA = 32;
  localparam int D  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freelist_if #(.WIDTH(W), .NARCH(NA)) fl_if ();

  freelist #(.WIDTH(W), .NARCH(NA)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fl      (fl_if)
  );

  int checks   = 0;
  int failures = 0;

  int fq[$];     // free registers in allocation order
  int pool[$];   // registers handed out and not yet freed
  int seen;      // allocations since reset, saturating at D
  bit err_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    pool.delete();
    for (int i = 0; i < D; i++) fq.push_back(NA + i);
    seen  = 0;
    err_m = 1'b0;
  endtask

  task automatic pool_drop(input int a);
    for (int i = 0; i < pool.size(); i++) begin
      if (pool[i] == a) begin
        pool.delete(i);
        return;
      end
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs and state, then
  // advance the model the way the clock edge will.
  task automatic step(input logic [3:0] req, input logic [3:0] fen, input logic [4*W-1:0] f4);
    int  nreq, nfree, alloc, k, a;
    bit  stall, early;
    @(negedge clk);
    fl_if.i_req    = req;
    fl_if.i_freeEn = fen;
    fl_if.i_free4x = f4;
    #1;
    nreq  = $countones(req);
    stall = nreq > fq.size();
    check_eq("stall", 32'(fl_if.o_stall), 32'(stall));
    check_eq("count", 32'(fl_if.o_count), 32'(fq.size()));
`ifdef FREELIST_ERR_EN
    check_eq("err", 32'(fl_if.o_err), 32'(err_m));
`endif
    k = 0;
    for (int j = 0; j < 4; j++) begin
      a = 0;
      if (req[j] && !stall) begin
        a = fq[k];
        k++;
      end
      check_eq($sformatf("addr%0d", j), 32'(fl_if.o_addr4x[j*W +: W]), 32'(a));
    end
    alloc = stall ? 0 : nreq;
    nfree = 0;
    early = 1'b0;
    for (int j = 0; j < 4; j++) begin
      a = int'(f4[j*W +: W]);
      if (fen[j] && a != 0) begin
        nfree++;
        if (a < NA && seen < D) early = 1'b1;
      end
    end
    if (fq.size() + nfree - alloc > D || early) err_m = 1'b1;
    seen = (seen + alloc > D) ? D : seen + alloc;
    for (int i = 0; i < alloc; i++) pool.push_back(fq.pop_front());
    for (int j = 0; j < 4; j++) begin
      a = int'(f4[j*W +: W]);
      if (fen[j] && a != 0) fq.push_back(a);
    end
  endtask

  function automatic logic [4*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [4*W-1:0] v;
    v = {W'(a3), W'(a2), W'(a1), W'(a0)};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fl_if.i_req    = '0;
    fl_if.i_freeEn = '0;
    fl_if.i_free4x = '0;
    #1;
    model_reset();
    check_eq("rst_count", 32'(fl_if.o_count), 32'(D));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]     rq, fe;
  logic [4*W-1:0] fv;
  int             pick;

  initial begin
    fl_if.i_req    = '0;
    fl_if.i_freeEn = '0;
    fl_if.i_free4x = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-width allocation from reset.
    step(4'b1111, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);

    // Sparse request packs toward the lowest slots in list order.
    do_reset();
    step(4'b1010, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);

    // Drain to 3, stall on 4, then take the last three.
    do_reset();
    repeat (7) step(4'b1111, 4'b0000, '0);
    step(4'b0001, 4'b0000, '0);
    step(4'b1111, 4'b0000, '0);
    step(4'b0111, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);

    // Refill to 2, then alloc two while freeing 40 and 41 in the same cycle.
    pool_drop(42); pool_drop(43);
    step(4'b0000, 4'b0011, pack4(42, 43, 0, 0));
    pool_drop(40); pool_drop(41);
    step(4'b0011, 4'b0101, pack4(40, 0, 41, 0));
    step(4'b0001, 4'b0000, '0);
    step(4'b0001, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);

    // Freed p0 is ignored.
    step(4'b0000, 4'b0001, '0);
    step(4'b0000, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);

    // Asynchronous reset in the middle of a burst at count 10.
    do_reset();
    repeat (5) step(4'b1111, 4'b0000, '0);
    step(4'b0011, 4'b0000, '0);
    @(negedge clk);
    fl_if.i_req    = 4'b1111;
    fl_if.i_freeEn = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_count", 32'(fl_if.o_count), 32'(D));
    check_eq("midrst_stall", 32'(fl_if.o_stall), 32'd0);
    check_eq("midrst_addr0", 32'(fl_if.o_addr4x[0 +: W]), 32'(NA));
    fl_if.i_req = '0;
    #1;
    check_eq("midrst_idle", 32'(fl_if.o_addr4x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 4'b0000, '0);

    // Random traffic; frees are drawn only from registers currently handed out.
    for (int c = 0; c < 3000; c++) begin
      rq = 4'($urandom);
      fe = '0;
      fv = W*4'($urandom);
      fv = {$urandom, $urandom};
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 99) < 45) begin
          if ($urandom_range(0, 9) == 0) begin
            fe[j] = 1'b1;
            fv[j*W +: W] = '0;
          end else if (pool.size() > 0) begin
            pick = $urandom_range(0, pool.size() - 1);
            fe[j] = 1'b1;
            fv[j*W +: W] = W'(pool[pick]);
            pool.delete(pick);
          end
        end
      end
      step(rq, fe, fv);
    end
    step(4'b0000, 4'b0000, '0);

`ifdef FREELIST_ERR_EN
    // Overflowing free at full capacity sets the sticky error.
    do_reset();
    step(4'b0000, 4'b0001, pack4(50, 0, 0, 0));
    step(4'b0000, 4'b0000, '0);
    step(4'b0001, 4'b0000, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the 4-wide rename stage. Hands out up to four free physical destination registers per cycle, and recycles up to four registers per cycle released at commit. Sits directly upstream of the busy table: its allocated addresses drive the busy table's set-address bus, and that bus uses the same packing as `o_addr4x`.

## Interface
- `WIDTH`, 6, physical register address width (2^WIDTH physical registers).
- `NARCH`, 32, architectural registers; p0..p(NARCH-1) are mapped at reset and never in the list initially.
- Derived: `DEPTH` = 2^WIDTH − NARCH; must be a power of two (default 32).
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req`  in  4  per-slot allocation request (slot has rd ≠ x0).
- `o_addr4x`  out  4*WIDTH  allocated physical regs, slot j at bits [(j+1)*WIDTH-1 : j*WIDTH].
- `o_stall`  out  1  request cannot be satisfied this cycle.
- `i_freeEn`  in  4  per-slot free enable from commit.
- `i_free4x`  in  4*WIDTH  registers being released, same packing as `o_addr4x`.
- `o_count`  out  $clog2(DEPTH)+1  registered number of free entries.

## Operation
- Circular buffer `mem[DEPTH]` of WIDTH-bit entries, with a head pointer (allocate) and a tail pointer (free).
  - Both pointers are $clog2(DEPTH) bits and wrap naturally.
  - `count` is held as a register.
- Reset: head=0, tail=0, count=DEPTH, mem[i]=NARCH+i.
- Allocation, all-or-nothing:
  - n_req = popcount(i_req).
  - `o_stall` = (n_req > count), combinational.
  - Slot j output: if i_req[j], it gets mem[head + k_j], where k_j = number of requested slots below j.
  - Unrequested slots, and all slots while stalled, output 0. p0 is harmless to the busy table.
  - If not stalled, head advances by n_req at the clock edge; if stalled, head is unchanged.
- Free:
  - Every slot with i_freeEn[j]=1 and address ≠ 0 is written at mem[tail + m_j], where m_j = count of valid frees below j.
  - Tail advances by the number of valid frees (n_free).
  - Freed p0 is silently ignored.
- Simultaneous alloc and free: count' = count − (stalled ? 0 : n_req) + n_free.
- No bypass: a register freed in cycle t is allocatable from cycle t+1 at the earliest.
- Freeing more than the free capacity (count + n_free > DEPTH) is illegal. Without the error option the behaviour is undefined; the error option below flags it.

## Timing
- `o_addr4x` and `o_stall` are combinational from registered state plus `i_req`. There is no allocation latency: addresses are valid in the request cycle and consumed at that cycle's rising edge.
- `o_count` updates one edge after the alloc/free.
- Reset is asynchronous, including mid-operation: state returns immediately to reset contents and `o_count`=DEPTH. `o_addr4x` then shows 0 unless `i_req` is asserted.
- Reset values: `o_count`=DEPTH; `o_stall`=0 for any request while count ≥ 4.

## Configuration
- `FREELIST_ERR_EN` defined:
  - Adds output `o_err` (1 bit), reset 0.
  - Set at the edge where a free overflows (count + n_free − allocated > DEPTH).
  - Also set when any enabled free address is < NARCH but ≠ 0 during the first DEPTH allocations since reset. This is a simple "never allocated" check, tracked with an allocated-since-reset counter saturating at DEPTH.
  - Sticky until reset.
- Not defined: no `o_err` port and no checking logic.

## Structure
- Shared rename package holds:
  - WIDTH/NARCH defaults.
  - DEPTH derivation.
  - The 4-slot packing helper (slot index → bit range).
- One sub-module, `freelist_prefix`: 4-bit mask in → exclusive prefix counts k_0..k_3 plus total popcount. Instantiated twice, for `i_req` and for the valid-free mask.

## Test plan
1. Reset, then `i_req`=4'b1111 → `o_addr4x` = {35,34,33,32}, `o_stall`=0; next cycle `o_count`=28.
2. After reset, `i_req`=4'b1010 → slot1=32, slot3=33, slots 0 and 2 = 0; `o_count`=30 next cycle.
3. Drain to count=3, `i_req`=4'b1111 → `o_stall`=1, all outputs 0, count stays 3. Then `i_req`=4'b0111 → three addresses issued, count becomes 0.
4. count=2, `i_req`=4'b0011 while freeing {40 in slot0, 41 in slot2} → count stays 2. Later allocations return 40 then 41 in that order after the wrap, never in the same cycle as the free.
5. `i_freeEn`=4'b0001 with address 0 → count unchanged, tail unchanged.
6. Assert `i_rst_n` low mid-burst (count=10) → `o_count`=32 immediately. Then `i_req`=4'b0001 → 32.
   - With `FREELIST_ERR_EN`: a free of 50 at count=32 → `o_err`=1 and stays 1 until reset.
